reg_writeback_arbiter: RTL and testbench

Collects completed results from the execution units and drives the physical register file write ports. It is the writer side of the register file's write interface.
- Each source has a small FIFO. A round-robin arbiter grants up to NUM_WRITE_PORTS heads per cycle.
- Write-port outputs are registered, so the register file sees clean wr_en/wr_preg/wr_data signals.
- It guarantees no two write ports target the same physical register in one cycle.

---
 rtl/reg_writeback_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_reg_writeback_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arbiter.sv
// Writeback arbiter: per-source result FIFOs feeding
// registered register-file write ports, round-robin fair.
module reg_writeback_arbiter #(
  parameter int WORD_SIZE       = 64,
  parameter int NUM_PHYS_REGS   = 128,
  parameter int NUM_SRCS        = 4,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int FIFO_DEPTH      = 2,
  localparam int PREG_W = $clog2(NUM_PHYS_REGS)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_flush,
  input  logic [NUM_SRCS-1:0]               i_src_valid,
  output logic [NUM_SRCS-1:0]               o_src_ready,
  input  logic [NUM_SRCS*PREG_W-1:0]        i_src_preg,
  input  logic [NUM_SRCS*WORD_SIZE-1:0]     i_src_data,
  output logic [NUM_WRITE_PORTS-1:0]        o_wr_en,
  output logic [NUM_WRITE_PORTS*PREG_W-1:0] o_wr_preg,
  output logic [NUM_WRITE_PORTS*WORD_SIZE-1:0] o_wr_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [PREG_W-1:0]    r_fifo_preg [NUM_SRCS][FIFO_DEPTH];
  logic [WORD_SIZE-1:0] r_fifo_data [NUM_SRCS][FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr [NUM_SRCS];
  logic [PTR_W-1:0]     r_rptr [NUM_SRCS];
  logic [CNT_W-1:0]     r_cnt  [NUM_SRCS];
  logic [RR_W-1:0]      r_rr;

  logic [NUM_WRITE_PORTS-1:0]        r_wr_en;
  logic [NUM_WRITE_PORTS*PREG_W-1:0] r_wr_preg;
  logic [NUM_WRITE_PORTS*WORD_SIZE-1:0] r_wr_data;

  logic [NUM_SRCS-1:0]  w_ready;
  logic [NUM_SRCS-1:0]  w_push;
  logic [NUM_SRCS-1:0]  w_pop;
  logic [PREG_W-1:0]    w_head_preg [NUM_SRCS];
  logic [WORD_SIZE-1:0] w_head_data [NUM_SRCS];

  logic [NUM_WRITE_PORTS-1:0] w_gnt_vld;
  logic [PREG_W-1:0]    w_gnt_preg [NUM_WRITE_PORTS];
  logic [WORD_SIZE-1:0] w_gnt_data [NUM_WRITE_PORTS];
  logic                 w_any;
  logic [RR_W-1:0]      w_rr_nxt;

  // Ready depends only on the registered count and reset.
  always_comb begin
    for (int i = 0; i < NUM_SRCS; i++) begin
      w_ready[i] = i_rst && (r_cnt[i] != FULL_CNT);
    end
  end

  assign o_src_ready = w_ready;
  assign w_push = i_src_valid & w_ready & {NUM_SRCS{~i_flush}};

  // Head entry of every source FIFO.
  always_comb begin
    for (int i = 0; i < NUM_SRCS; i++) begin
      w_head_preg[i] = r_fifo_preg[i][r_rptr[i]];
      w_head_data[i] = r_fifo_data[i][r_rptr[i]];
    end
  end

  // Rotating scan from r_rr, granting non-colliding heads in port order.
  always_comb begin
    int  n;
    int  s;
    logic hit;
    logic elig;
    n         = 0;
    s         = 0;
    hit       = 1'b0;
    elig      = 1'b0;
    w_pop     = '0;
    w_gnt_vld = '0;
    w_any     = 1'b0;
    w_rr_nxt  = r_rr;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      w_gnt_preg[p] = '0;
      w_gnt_data[p] = '0;
    end
    for (int k = 0; k < NUM_SRCS; k++) begin
      s = (int'(r_rr) + k) % NUM_SRCS;
      for (int j = 0; j < NUM_SRCS; j++) begin
        if (j == s) begin
          hit = 1'b0;
          for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (w_gnt_vld[p] &&
                (w_gnt_preg[p] == w_head_preg[j])) begin
              hit = 1'b1;
            end
          end
          elig = (r_cnt[j] != '0) && !hit &&
                 (n < NUM_WRITE_PORTS);
          if (elig) begin
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
              if (p == n) begin
                w_gnt_vld[p]  = 1'b1;
                w_gnt_preg[p] = w_head_preg[j];
                w_gnt_data[p] = w_head_data[j];
              end
            end
            w_pop[j] = 1'b1;
            w_any    = 1'b1;
            w_rr_nxt = RR_W'((j + 1) % NUM_SRCS);
            n        = n + 1;
          end
        end
      end
    end
    if (i_flush) begin
      w_pop     = '0;
      w_gnt_vld = '0;
      w_any     = 1'b0;
    end
  end

  // FIFO storage; pointers below keep stale slots harmless.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_SRCS; i++) begin
      if (w_push[i]) begin
        r_fifo_preg[i][r_wptr[i]] <=
          i_src_preg[i*PREG_W +: PREG_W];
        r_fifo_data[i][r_wptr[i]] <=
          i_src_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // FIFO pointers, counts and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NUM_SRCS; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_rr <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < NUM_SRCS; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_rr <= '0;
    end else begin
      for (int i = 0; i < NUM_SRCS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i])
                             - CNT_W'(w_pop[i]);
      end
      if (w_any) r_rr <= w_rr_nxt;
    end
  end

  // Registered write ports; idle ports keep address and data.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_en   <= '0;
      r_wr_preg <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_gnt_vld;
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (w_gnt_vld[p]) begin
          r_wr_preg[p*PREG_W +: PREG_W]       <= w_gnt_preg[p];
          r_wr_data[p*WORD_SIZE +: WORD_SIZE] <= w_gnt_data[p];
        end
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_preg = r_wr_preg;
  assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter:
// latency, round-robin, collisions, backpressure, flush, reset.
module tb_reg_writeback_arbiter;

  localparam int PW = 7;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [3:0]    src_valid;
  logic [3:0]    src_ready;
  logic [4*PW-1:0] src_preg;
  logic [4*DW-1:0] src_data;
  logic [1:0]    wr_en;
  logic [2*PW-1:0] wr_preg;
  logic [2*DW-1:0] wr_data;

  int total = 0;
  int bad   = 0;

  reg_writeback_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_src_valid (src_valid),
    .o_src_ready (src_ready),
    .i_src_preg  (src_preg),
    .i_src_data  (src_data),
    .o_wr_en     (wr_en),
    .o_wr_preg   (wr_preg),
    .o_wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] wp(input int k);
    return wr_preg[k*PW +: PW];
  endfunction

  function automatic logic [DW-1:0] wd(input int k);
    return wr_data[k*DW +: DW];
  endfunction

  task automatic push(input int s, input logic [PW-1:0] p,
                      input logic [DW-1:0] d);
    src_valid[s] = 1'b1;
    src_preg[s*PW +: PW] = p;
    src_data[s*DW +: DW] = d;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (wr_en == 2'b11)
      chk("port_collision", 64'(wp(0) != wp(1)), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    src_valid = '0;
    src_preg = '0;
    src_data = '0;
    #12;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_preg", 64'(wr_preg), 64'd0);
    chk("rst_wr_data", wr_data[63:0], 64'd0);
    chk("rst_ready", 64'(src_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(src_ready), 64'hf);

    // single result, 2-cycle latency
    push(0, 7'd5, 64'hDEAD);
    step();
    idle();
    chk("t1_c1_en", 64'(wr_en), 64'd0);
    step();
    chk("t1_c2_en", 64'(wr_en), 64'b01);
    chk("t1_preg", 64'(wp(0)), 64'd5);
    chk("t1_data", wd(0), 64'hDEAD);
    step();
    chk("t1_c3_en", 64'(wr_en), 64'd0);

    // flush with empty FIFOs resets rr pointer
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl0_en", 64'(wr_en), 64'd0);

    // four sources, two ports
    for (int i = 0; i < 4; i++)
      push(i, 7'(10 + i), 64'(100 + i));
    step();
    idle();
    step();
    chk("t2_a_en", 64'(wr_en), 64'b11);
    chk("t2_a_p0", 64'(wp(0)), 64'd10);
    chk("t2_a_p1", 64'(wp(1)), 64'd11);
    chk("t2_a_d1", wd(1), 64'd101);
    step();
    chk("t2_b_en", 64'(wr_en), 64'b11);
    chk("t2_b_p0", 64'(wp(0)), 64'd12);
    chk("t2_b_p1", 64'(wp(1)), 64'd13);
    chk("t2_b_d0", wd(0), 64'd102);
    step();
    chk("t2_c_en", 64'(wr_en), 64'd0);

    // preg collision (rr back at 0)
    push(0, 7'd7, 64'hA0);
    push(1, 7'd7, 64'hA1);
    push(2, 7'd8, 64'hA2);
    step();
    idle();
    step();
    chk("t3_a_en", 64'(wr_en), 64'b11);
    chk("t3_a_p0", 64'(wp(0)), 64'd7);
    chk("t3_a_d0", wd(0), 64'hA0);
    chk("t3_a_p1", 64'(wp(1)), 64'd8);
    chk("t3_a_d1", wd(1), 64'hA2);
    step();
    chk("t3_b_en", 64'(wr_en), 64'b01);
    chk("t3_b_p0", 64'(wp(0)), 64'd7);
    chk("t3_b_d0", wd(0), 64'hA1);
    chk("t3_b_p1_hold", 64'(wp(1)), 64'd8);
    step();
    chk("t3_c_en", 64'(wr_en), 64'd0);

    // backpressure on src1 (rr now 2)
    push(1, 7'd20, 64'h21);
    push(2, 7'd30, 64'h32);
    push(3, 7'd31, 64'h33);
    step();
    idle();
    push(1, 7'd21, 64'h22);
    step();
    chk("t4_full", 64'(src_ready[1]), 64'd0);
    chk("t4_a_en", 64'(wr_en), 64'b11);
    chk("t4_a_p0", 64'(wp(0)), 64'd30);
    chk("t4_a_p1", 64'(wp(1)), 64'd31);
    push(1, 7'd22, 64'h23);
    step();
    chk("t4_b_ready", 64'(src_ready[1]), 64'd1);
    chk("t4_b_en", 64'(wr_en), 64'b01);
    chk("t4_b_p0", 64'(wp(0)), 64'd20);
    chk("t4_b_d0", wd(0), 64'h21);
    step();
    idle();
    chk("t4_c_en", 64'(wr_en), 64'b01);
    chk("t4_c_p0", 64'(wp(0)), 64'd21);
    chk("t4_c_d0", wd(0), 64'h22);
    step();
    chk("t4_d_en", 64'(wr_en), 64'b01);
    chk("t4_d_p0", 64'(wp(0)), 64'd22);
    chk("t4_d_d0", wd(0), 64'h23);
    step();
    chk("t4_e_en", 64'(wr_en), 64'd0);

    // flush with two entries held in src3
    flush = 1'b1;
    step();
    flush = 1'b0;
    push(0, 7'd60, 64'h60);
    push(1, 7'd61, 64'h61);
    push(3, 7'd40, 64'h40);
    step();
    idle();
    push(3, 7'd41, 64'h41);
    step();
    idle();
    chk("t5_pre_en", 64'(wr_en), 64'b11);
    chk("t5_pre_p0", 64'(wp(0)), 64'd60);
    chk("t5_pre_full", 64'(src_ready[3]), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_fl_en", 64'(wr_en), 64'd0);
    chk("t5_fl_ready", 64'(src_ready[3]), 64'd1);
    push(3, 7'd42, 64'h4242);
    step();
    idle();
    chk("t5_c1_en", 64'(wr_en), 64'd0);
    step();
    chk("t5_c2_en", 64'(wr_en), 64'b01);
    chk("t5_c2_p0", 64'(wp(0)), 64'd42);
    chk("t5_c2_d0", wd(0), 64'h4242);
    step();
    chk("t5_c3_en", 64'(wr_en), 64'd0);

    // reset with six entries buffered (rr at 0)
    for (int i = 0; i < 4; i++)
      push(i, 7'(70 + i), 64'(16'h70 + i));
    step();
    for (int i = 0; i < 4; i++)
      push(i, 7'(74 + i), 64'(16'h74 + i));
    step();
    idle();
    chk("t6_en", 64'(wr_en), 64'b11);
    chk("t6_ready", 64'(src_ready), 64'b0011);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_rst_en", 64'(wr_en), 64'd0);
    chk("t6_rst_ready", 64'(src_ready), 64'd0);
    chk("t6_rst_preg", 64'(wr_preg), 64'd0);
    #3;
    rst = 1'b1;
    step();
    chk("t6_rel_ready", 64'(src_ready), 64'hf);
    chk("t6_rel_en0", 64'(wr_en), 64'd0);
    step();
    chk("t6_rel_en1", 64'(wr_en), 64'd0);
    push(2, 7'd99, 64'h99);
    step();
    idle();
    chk("t6_n1_en", 64'(wr_en), 64'd0);
    step();
    chk("t6_n2_en", 64'(wr_en), 64'b01);
    chk("t6_n2_p0", 64'(wp(0)), 64'd99);
    chk("t6_n2_d0", wd(0), 64'h99);
    step();
    chk("t6_n3_en", 64'(wr_en), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
